// File: rtl/md_pkg.sv
// Shared encodings, FSM state type and default latencies for the multiply/divide unit.
// Optional MD_MADD_EN build enables the madd/msub codes.
package md_pkg;

  localparam logic [4:0] MD_NONE  = 5'd0;
  localparam logic [4:0] MD_MULT  = 5'd1;
  localparam logic [4:0] MD_MULTU = 5'd2;
  localparam logic [4:0] MD_DIV   = 5'd3;
  localparam logic [4:0] MD_DIVU  = 5'd4;
  localparam logic [4:0] MD_MTHI  = 5'd5;
  localparam logic [4:0] MD_MTLO  = 5'd6;
  localparam logic [4:0] MD_MADD  = 5'd7;
  localparam logic [4:0] MD_MADDU = 5'd8;
  localparam logic [4:0] MD_MSUB  = 5'd9;
  localparam logic [4:0] MD_MSUBU = 5'd10;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdState_e;

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for the HI/LO unit: product, quotient/remainder,
// divide-by-zero hold and, when MD_MADD_EN is defined, multiply-accumulate.
module md_calc
  import md_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic               isSigned;
  logic signed [63:0] extA;
  logic signed [63:0] extB;
  logic signed [63:0] product;
  logic [31:0]        magA;
  logic [31:0]        magB;
  logic [31:0]        safeB;
  logic [31:0]        uQuot;
  logic [31:0]        uRem;
  logic [31:0]        quot;
  logic [31:0]        rem;

  always_comb begin
    isSigned = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    extA     = isSigned ? {{32{opA[31]}}, opA} : {32'b0, opA};
    extB     = isSigned ? {{32{opB[31]}}, opB} : {32'b0, opB};
    product  = extA * extB;

    // Divide on magnitudes so that 0x80000000 / -1 wraps cleanly instead of overflowing.
    magA  = (isSigned && opA[31]) ? -opA : opA;
    magB  = (isSigned && opB[31]) ? -opB : opB;
    safeB = (opB == 32'd0) ? 32'd1 : magB;
    uQuot = magA / safeB;
    uRem  = magA % safeB;
    quot  = (isSigned && (opA[31] ^ opB[31])) ? -uQuot : uQuot;
    rem   = (isSigned && opA[31]) ? -uRem : uRem;

    result = {hi, lo};
    case (op)
      MD_MULT, MD_MULTU: result = product;
      MD_DIV, MD_DIVU:   result = (opB == 32'd0) ? {hi, lo} : {rem, quot};
`ifdef MD_MADD_EN
      MD_MADD, MD_MADDU: result = {hi, lo} + product;
      MD_MSUB, MD_MSUBU: result = {hi, lo} - product;
`endif
      default:           result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding the HI/LO pair; busy stalls the pipe while a op runs.
// Optional MD_MADD_EN build adds madd/maddu/msub/msubu.
module md_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  ctrl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdState_e    state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic        accept;
  logic [31:0] opA, opB;
  logic [4:0]  opCode;
  logic [63:0] pending;
  logic [63:0] calcResult;

  function automatic logic isMdStart(input logic [4:0] c);
    logic ok;
    ok = (c == MD_MULT) || (c == MD_MULTU) || (c == MD_DIV) || (c == MD_DIVU);
`ifdef MD_MADD_EN
    ok = ok || (c == MD_MADD) || (c == MD_MADDU) || (c == MD_MSUB) || (c == MD_MSUBU);
`endif
    return ok;
  endfunction

  function automatic logic isDivOp(input logic [4:0] c);
    return (c == MD_DIV) || (c == MD_DIVU);
  endfunction

  md_calc uCalc (
    .op     (opCode),
    .opA    (opA),
    .opB    (opB),
    .hi     (hi),
    .lo     (lo),
    .result (calcResult)
  );

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start && isMdStart(ctrl)) begin
          accept    = 1'b1;
          stateNext = RUN;
          cntNext   = isDivOp(ctrl) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
      end
      RUN: begin
        cntNext = cnt - 1'b1;
        if (cnt == CNT_W'(1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  assign busy = (state == RUN);

  // The long divide/multiply path is captured into pending during the busy window and
  // committed from there, so both latencies must be at least 2 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opA     <= '0;
      opB     <= '0;
      opCode  <= MD_NONE;
      pending <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      if (accept) begin
        opA    <= a;
        opB    <= b;
        opCode <= ctrl;
      end
      if (state == RUN) pending <= calcResult;
      if (state == RUN && cnt == CNT_W'(1)) begin
        {hi, lo} <= pending;
      end else if (state == IDLE) begin
        if (ctrl == MD_MTHI) hi <= a;
        if (ctrl == MD_MTLO) lo <= a;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: busy windows, HI/LO results, boundaries, async reset, madd option.
module tb_md_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  ctrl;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy;

  int tests = 0;
  int fails = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .ctrl  (ctrl),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns 1 ns after that edge.
  task automatic issue(input logic [4:0] c, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    ctrl  = c;
    a     = va;
    b     = vb;
    step();
    start = 1'b0;
    ctrl  = MD_NONE;
  endtask

  // Expect busy high for exactly n cycles starting now, then low.
  task automatic busyWindow(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s busy[%0d]", tag, i), {31'b0, busy}, 32'd1);
      step();
    end
    check($sformatf("%s busy end", tag), {31'b0, busy}, 32'd0);
  endtask

  task automatic writeHiLo(input logic [4:0] c, input logic [31:0] va);
    ctrl = c;
    a    = va;
    step();
    ctrl = MD_NONE;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    ctrl  = MD_NONE;
    a     = '0;
    b     = '0;
    step();
    step();
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset busy", {31'b0, busy}, 32'd0);
    reset = 1'b0;
    step();

    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    busyWindow("mult", 5);
    check("mult hi", hi, 32'hFFFF_FFFF);
    check("mult lo", lo, 32'hFFFF_FFFA);

    issue(MD_DIVU, 32'd100, 32'd7);
    busyWindow("divu", 10);
    check("divu hi", hi, 32'd2);
    check("divu lo", lo, 32'd14);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    busyWindow("div", 10);
    check("div hi", hi, 32'hFFFF_FFFF);
    check("div lo", lo, 32'hFFFF_FFFD);

    issue(MD_DIV, 32'd5, 32'd0);
    busyWindow("div0", 10);
    check("div0 hi", hi, 32'hFFFF_FFFF);
    check("div0 lo", lo, 32'hFFFF_FFFD);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busyWindow("divovf", 10);
    check("divovf hi", hi, 32'h0);
    check("divovf lo", lo, 32'h8000_0000);

    writeHiLo(MD_MTHI, 32'h1234_5678);
    check("mthi hi", hi, 32'h1234_5678);
    check("mthi lo", lo, 32'h8000_0000);
    check("mthi busy", {31'b0, busy}, 32'd0);

    // mtlo and a second start during a mult must be ignored.
    issue(MD_MULTU, 32'd6, 32'd7);
    check("midmul busy", {31'b0, busy}, 32'd1);
    writeHiLo(MD_MTLO, 32'hDEAD_BEEF);
    check("midmul mtlo lo", lo, 32'h8000_0000);
    start = 1'b1;
    ctrl  = MD_DIVU;
    a     = 32'd1;
    b     = 32'd1;
    step();
    start = 1'b0;
    ctrl  = MD_NONE;
    step();
    step();
    step();
    check("midmul done busy", {31'b0, busy}, 32'd0);
    check("midmul hi", hi, 32'h0);
    check("midmul lo", lo, 32'd42);
    step();
    check("midmul no restart", {31'b0, busy}, 32'd0);

    start = 1'b1;
    ctrl  = 5'd20;
    a     = 32'h5555_5555;
    step();
    start = 1'b0;
    ctrl  = MD_NONE;
    check("badctrl busy", {31'b0, busy}, 32'd0);
    check("badctrl hi", hi, 32'h0);
    check("badctrl lo", lo, 32'd42);

    // Async reset during the third busy cycle.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    step();
    check("prerst busy", {31'b0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst busy", {31'b0, busy}, 32'd0);
    check("midrst hi", hi, 32'h0);
    check("midrst lo", lo, 32'h0);
    #1;
    reset = 1'b0;
    step();
    check("postrst hi", hi, 32'h0);
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    busyWindow("multu", 5);
    check("multu hi", hi, 32'hFFFF_FFFE);
    check("multu lo", lo, 32'h0000_0001);

    writeHiLo(MD_MTHI, 32'h0);
    writeHiLo(MD_MTLO, 32'd10);
    check("preacc lo", lo, 32'd10);
    issue(MD_MADD, 32'd3, 32'd4);
`ifdef MD_MADD_EN
    busyWindow("madd", 5);
    check("madd hi", hi, 32'h0);
    check("madd lo", lo, 32'd22);
`else
    check("madd off busy", {31'b0, busy}, 32'd0);
    step();
    check("madd off hi", hi, 32'h0);
    check("madd off lo", lo, 32'd10);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
